pipe_stage_reg: RTL and testbench

Generic parametrised pipeline-stage register for the five-stage MIPS core, replacing the hand-written per-stage registers (F/D, D/E, E/M, M/W). It carries a payload word, PC, branch-delay flag, valid bit and a precise-exception record across one stage boundary. It applies the core-wide stall / exception-request / eret priority rules and keeps saturating stall and bubble counters for performance debug.

---
 rtl/core_pkg.sv | 18 +
 rtl/sat_counter.sv | 22 ++
 rtl/pipe_stage_reg.sv | 107 ++++++++++
 tb/tb_pipe_stage_reg.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Core-wide constants shared by the pipeline stages: exception-code width,
// CP0 ExcCode values and the reset / exception-handler vectors.
package core_pkg;

  localparam int unsigned EXC_W = 5;

  typedef enum logic [EXC_W-1:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic MIPS pipeline-stage register: payload, PC, delay-slot flag, valid and
// precise-exception record, with stall/flush priority and perf counters.
module pipe_stage_reg #(
  parameter int unsigned PAYLOAD_W       = 64,
  parameter int unsigned EXC_W           = core_pkg::EXC_W,
  parameter logic [31:0] RESET_PC        = core_pkg::RESET_PC,
  parameter logic [31:0] HANDLER_PC      = core_pkg::HANDLER_PC,
  parameter bit          KEEP_PC_ON_ERET = 1'b1,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall_i,
  input  logic                 req_i,
  input  logic                 eret_i,
  input  logic                 cnt_clr_i,
  input  logic                 in_valid,
  input  logic [31:0]          in_pc,
  input  logic                 in_bd,
  input  logic                 in_exc_valid,
  input  logic [EXC_W-1:0]     in_exc_code,
  input  logic                 lcl_exc_valid,
  input  logic [EXC_W-1:0]     lcl_exc_code,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  output logic [31:0]          out_pc,
  output logic                 out_bd,
  output logic                 out_exc_valid,
  output logic [EXC_W-1:0]     out_exc_code,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
);

  logic             nxt_exc_valid;
  logic [EXC_W-1:0] nxt_exc_code;
  logic             stall_inc;
  logic             bubble_inc;

  // Upstream exception wins over one raised at this boundary; empty slots carry none.
  always_comb begin
    nxt_exc_valid = 1'b0;
    nxt_exc_code  = '0;
    if (in_valid && in_exc_valid) begin
      nxt_exc_valid = 1'b1;
      nxt_exc_code  = in_exc_code;
    end else if (in_valid && lcl_exc_valid) begin
      nxt_exc_valid = 1'b1;
      nxt_exc_code  = lcl_exc_code;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_pc        <= RESET_PC;
      out_bd        <= 1'b0;
      out_exc_valid <= 1'b0;
      out_exc_code  <= '0;
      out_payload   <= '0;
    end else if (req_i) begin
      out_valid     <= 1'b0;
      out_pc        <= HANDLER_PC;
      out_bd        <= 1'b0;
      out_exc_valid <= 1'b0;
      out_exc_code  <= '0;
      out_payload   <= '0;
    end else if (stall_i) begin
      // hold everything; a concurrent eret is dropped and must be re-issued
    end else if (eret_i) begin
      out_valid     <= 1'b0;
      out_pc        <= KEEP_PC_ON_ERET ? out_pc : 32'h0000_0000;
      out_bd        <= 1'b0;
      out_exc_valid <= 1'b0;
      out_exc_code  <= '0;
      out_payload   <= '0;
    end else begin
      out_valid     <= in_valid;
      out_pc        <= in_pc;
      out_bd        <= in_bd;
      out_exc_valid <= nxt_exc_valid;
      out_exc_code  <= nxt_exc_code;
      out_payload   <= in_payload;
    end
  end

  // A bubble is any cycle that loads out_valid=0 other than by reset or hold.
  assign stall_inc  = stall_i & ~req_i;
  assign bubble_inc = req_i | (~stall_i & (eret_i | ~in_valid));

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .clr   (cnt_clr_i),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bubble_inc),
    .clr   (cnt_clr_i),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: default instance, a clear-PC-on-eret
// instance and a 2-bit-counter instance share one stimulus stream.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset, stall_i, req_i, eret_i, cnt_clr_i;
  logic        in_valid, in_bd, in_exc_valid, lcl_exc_valid;
  logic [31:0] in_pc;
  logic [4:0]  in_exc_code, lcl_exc_code;
  logic [63:0] in_payload;

  logic        a_valid, a_bd, a_exc_valid;
  logic [31:0] a_pc;
  logic [4:0]  a_exc_code;
  logic [63:0] a_payload;
  logic [15:0] a_stall_cnt, a_bubble_cnt;

  logic        b_valid, b_bd, b_exc_valid;
  logic [31:0] b_pc;
  logic [4:0]  b_exc_code;
  logic [63:0] b_payload;
  logic [15:0] b_stall_cnt, b_bubble_cnt;

  logic        c_valid, c_bd, c_exc_valid;
  logic [31:0] c_pc;
  logic [4:0]  c_exc_code;
  logic [63:0] c_payload;
  logic [1:0]  c_stall_cnt, c_bubble_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.PAYLOAD_W(64)) dut_a (
    .clk(clk), .reset(reset), .stall_i(stall_i), .req_i(req_i), .eret_i(eret_i),
    .cnt_clr_i(cnt_clr_i), .in_valid(in_valid), .in_pc(in_pc), .in_bd(in_bd),
    .in_exc_valid(in_exc_valid), .in_exc_code(in_exc_code),
    .lcl_exc_valid(lcl_exc_valid), .lcl_exc_code(lcl_exc_code), .in_payload(in_payload),
    .out_valid(a_valid), .out_pc(a_pc), .out_bd(a_bd), .out_exc_valid(a_exc_valid),
    .out_exc_code(a_exc_code), .out_payload(a_payload),
    .stall_cnt(a_stall_cnt), .bubble_cnt(a_bubble_cnt));

  pipe_stage_reg #(.PAYLOAD_W(64), .KEEP_PC_ON_ERET(1'b0)) dut_b (
    .clk(clk), .reset(reset), .stall_i(stall_i), .req_i(req_i), .eret_i(eret_i),
    .cnt_clr_i(cnt_clr_i), .in_valid(in_valid), .in_pc(in_pc), .in_bd(in_bd),
    .in_exc_valid(in_exc_valid), .in_exc_code(in_exc_code),
    .lcl_exc_valid(lcl_exc_valid), .lcl_exc_code(lcl_exc_code), .in_payload(in_payload),
    .out_valid(b_valid), .out_pc(b_pc), .out_bd(b_bd), .out_exc_valid(b_exc_valid),
    .out_exc_code(b_exc_code), .out_payload(b_payload),
    .stall_cnt(b_stall_cnt), .bubble_cnt(b_bubble_cnt));

  pipe_stage_reg #(.PAYLOAD_W(64), .CNT_W(2)) dut_c (
    .clk(clk), .reset(reset), .stall_i(stall_i), .req_i(req_i), .eret_i(eret_i),
    .cnt_clr_i(cnt_clr_i), .in_valid(in_valid), .in_pc(in_pc), .in_bd(in_bd),
    .in_exc_valid(in_exc_valid), .in_exc_code(in_exc_code),
    .lcl_exc_valid(lcl_exc_valid), .lcl_exc_code(lcl_exc_code), .in_payload(in_payload),
    .out_valid(c_valid), .out_pc(c_pc), .out_bd(c_bd), .out_exc_valid(c_exc_valid),
    .out_exc_code(c_exc_code), .out_payload(c_payload),
    .stall_cnt(c_stall_cnt), .bubble_cnt(c_bubble_cnt));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; stall_i = 1'b0; req_i = 1'b0; eret_i = 1'b0; cnt_clr_i = 1'b0;
    in_valid = 1'b0; in_pc = '0; in_bd = 1'b0; in_exc_valid = 1'b0; in_exc_code = '0;
    lcl_exc_valid = 1'b0; lcl_exc_code = '0; in_payload = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1; stall_i = 1'b1; in_valid = 1'b1; in_pc = 32'hdead_beef; in_payload = 64'hffff;
    step();
    step();
    reset = 1'b0; stall_i = 1'b0; in_valid = 1'b0;
    n_checks++;
    if ({a_valid, a_bd, a_exc_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000", {a_valid, a_bd, a_exc_valid});
    end
    n_checks++;
    if (a_pc !== 32'h0 || a_exc_code !== 5'd0 || a_payload !== 64'h0) begin
      n_fail++; $display("FAIL reset_fields: pc=%h code=%0d payload=%h want 0/0/0", a_pc, a_exc_code, a_payload);
    end
    n_checks++;
    if (a_stall_cnt !== 16'd0 || a_bubble_cnt !== 16'd0 || c_stall_cnt !== 2'd0) begin
      n_fail++; $display("FAIL reset_counters: stall=%0d bubble=%0d c_stall=%0d want 0", a_stall_cnt, a_bubble_cnt, c_stall_cnt);
    end
  endtask

  task automatic test_capture();
    in_valid = 1'b1; in_pc = 32'h3000; in_payload = 64'h1234;
    step();
    n_checks++;
    if (a_valid !== 1'b1 || a_pc !== 32'h3000 || a_payload !== 64'h1234) begin
      n_fail++; $display("FAIL capture: valid=%b pc=%h payload=%h want 1/3000/1234", a_valid, a_pc, a_payload);
    end
    n_checks++;
    if (a_exc_valid !== 1'b0 || a_exc_code !== 5'd0 || a_bubble_cnt !== 16'd0) begin
      n_fail++; $display("FAIL capture_exc: exc=%b code=%0d bubble=%0d want 0/0/0", a_exc_valid, a_exc_code, a_bubble_cnt);
    end
  endtask

  task automatic test_stall();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_pc = 32'h4000 + 32'(i); in_payload = 64'h5555 + 64'(i); in_bd = 1'b1; in_valid = 1'(i & 1);
      eret_i = (i == 2);
      step();
      n_checks++;
      if (a_valid !== 1'b1 || a_pc !== 32'h3000 || a_payload !== 64'h1234 || a_bd !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold[%0d]: valid=%b pc=%h payload=%h bd=%b want 1/3000/1234/0", i, a_valid, a_pc, a_payload, a_bd);
      end
    end
    eret_i = 1'b0;
    n_checks++;
    if (a_stall_cnt !== 16'd3 || a_bubble_cnt !== 16'd0) begin
      n_fail++; $display("FAIL stall_counts: stall=%0d bubble=%0d want 3/0", a_stall_cnt, a_bubble_cnt);
    end
  endtask

  task automatic test_req_over_stall();
    stall_i = 1'b1; req_i = 1'b1; in_valid = 1'b1; in_pc = 32'h3010; in_bd = 1'b1;
    in_payload = 64'h9999; in_exc_valid = 1'b1; in_exc_code = 5'd10;
    step();
    stall_i = 1'b0; req_i = 1'b0; in_exc_valid = 1'b0; in_bd = 1'b0;
    n_checks++;
    if (a_pc !== 32'h4180 || a_valid !== 1'b0 || a_payload !== 64'h0 || a_bd !== 1'b0 || a_exc_valid !== 1'b0) begin
      n_fail++; $display("FAIL req_flush: pc=%h valid=%b payload=%h bd=%b exc=%b want 4180/0/0/0/0", a_pc, a_valid, a_payload, a_bd, a_exc_valid);
    end
    n_checks++;
    if (a_stall_cnt !== 16'd3 || a_bubble_cnt !== 16'd1) begin
      n_fail++; $display("FAIL req_counts: stall=%0d bubble=%0d want 3/1", a_stall_cnt, a_bubble_cnt);
    end
  endtask

  task automatic test_eret();
    in_valid = 1'b1; in_pc = 32'h3008; in_bd = 1'b1; in_payload = 64'habcd;
    step();
    eret_i = 1'b1; in_pc = 32'h7777;
    step();
    eret_i = 1'b0;
    n_checks++;
    if (a_pc !== 32'h3008 || a_valid !== 1'b0 || a_bd !== 1'b0 || a_payload !== 64'h0) begin
      n_fail++; $display("FAIL eret_keep: pc=%h valid=%b bd=%b payload=%h want 3008/0/0/0", a_pc, a_valid, a_bd, a_payload);
    end
    n_checks++;
    if (b_pc !== 32'h0 || b_valid !== 1'b0) begin
      n_fail++; $display("FAIL eret_clear: pc=%h valid=%b want 0/0", b_pc, b_valid);
    end
    in_pc = 32'h300c; in_bd = 1'b0; in_payload = 64'hbeef;
    step();
    eret_i = 1'b1; stall_i = 1'b1;
    step();
    eret_i = 1'b0; stall_i = 1'b0;
    n_checks++;
    if (a_valid !== 1'b1 || a_pc !== 32'h300c || b_pc !== 32'h300c || a_payload !== 64'hbeef) begin
      n_fail++; $display("FAIL eret_stall: valid=%b pc=%h bpc=%h payload=%h want 1/300c/300c/beef", a_valid, a_pc, b_pc, a_payload);
    end
    n_checks++;
    if (a_stall_cnt !== 16'd4 || a_bubble_cnt !== 16'd2) begin
      n_fail++; $display("FAIL eret_counts: stall=%0d bubble=%0d want 4/2", a_stall_cnt, a_bubble_cnt);
    end
  endtask

  task automatic test_exc_merge();
    in_valid = 1'b1; in_exc_valid = 1'b1; in_exc_code = core_pkg::EXC_OV;
    lcl_exc_valid = 1'b1; lcl_exc_code = core_pkg::EXC_ADEL;
    step();
    n_checks++;
    if (a_exc_valid !== 1'b1 || a_exc_code !== 5'd12) begin
      n_fail++; $display("FAIL exc_upstream: valid=%b code=%0d want 1/12", a_exc_valid, a_exc_code);
    end
    in_exc_valid = 1'b0;
    step();
    n_checks++;
    if (a_exc_valid !== 1'b1 || a_exc_code !== 5'd4) begin
      n_fail++; $display("FAIL exc_local: valid=%b code=%0d want 1/4", a_exc_valid, a_exc_code);
    end
    in_valid = 1'b0; in_exc_valid = 1'b1;
    step();
    n_checks++;
    if (a_exc_valid !== 1'b0 || a_exc_code !== 5'd0 || a_valid !== 1'b0 || a_bubble_cnt !== 16'd3) begin
      n_fail++; $display("FAIL exc_gated: exc=%b code=%0d valid=%b bubble=%0d want 0/0/0/3", a_exc_valid, a_exc_code, a_valid, a_bubble_cnt);
    end
    in_exc_valid = 1'b0; lcl_exc_valid = 1'b0; lcl_exc_code = '0; in_exc_code = '0;
  endtask

  task automatic test_saturate();
    cnt_clr_i = 1'b1;
    step();
    cnt_clr_i = 1'b0;
    n_checks++;
    if (a_stall_cnt !== 16'd0 || a_bubble_cnt !== 16'd0) begin
      n_fail++; $display("FAIL clr_override: stall=%0d bubble=%0d want 0/0", a_stall_cnt, a_bubble_cnt);
    end
    stall_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_checks++;
    if (c_stall_cnt !== 2'd3 || a_stall_cnt !== 16'd5) begin
      n_fail++; $display("FAIL stall_sat: c_stall=%0d a_stall=%0d want 3/5", c_stall_cnt, a_stall_cnt);
    end
    cnt_clr_i = 1'b1;
    step();
    cnt_clr_i = 1'b0; stall_i = 1'b0;
    n_checks++;
    if (c_stall_cnt !== 2'd0 || a_stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL clr_with_stall: c_stall=%0d a_stall=%0d want 0/0", c_stall_cnt, a_stall_cnt);
    end
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (c_bubble_cnt !== 2'd3 || a_bubble_cnt !== 16'd4) begin
      n_fail++; $display("FAIL bubble_sat: c_bubble=%0d a_bubble=%0d want 3/4", c_bubble_cnt, a_bubble_cnt);
    end
  endtask

  task automatic test_reset_mid_flush();
    in_valid = 1'b1; in_pc = 32'h5000; in_payload = 64'h42;
    step();
    reset = 1'b1; req_i = 1'b1; stall_i = 1'b1; cnt_clr_i = 1'b1;
    step();
    reset = 1'b0; req_i = 1'b0; stall_i = 1'b0; cnt_clr_i = 1'b0;
    n_checks++;
    if (a_pc !== 32'h0 || a_valid !== 1'b0 || a_payload !== 64'h0 || a_stall_cnt !== 16'd0 || a_bubble_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_mid_flush: pc=%h valid=%b payload=%h stall=%0d bubble=%0d want 0", a_pc, a_valid, a_payload, a_stall_cnt, a_bubble_cnt);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_capture();
    test_stall();
    test_req_over_stall();
    test_eret();
    test_exc_merge();
    test_saturate();
    test_reset_mid_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
